mode_sequencer: RTL and testbench

- Parametrised successor of the top-level mode-control FSM.
- Arbitrates NUM_MODES asynchronous trigger inputs and drives a two-phase transfer sequence into the transfer wrapper: command code first, then payload.
- Interactive modes stay resident, re-launch the payload on each new trigger, and exit on finish_i.
- Adds a per-phase timeout and an error counter.
- Sits between board buttons/host triggers and the BMP/UDP transfer wrapper.

---
 rtl/mode_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_mode_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mode_sequencer.sv
// Mode-control sequencer: arbitrates asynchronous mode triggers and drives the
// two-phase (command, payload) transfer handshake, with per-phase timeout.

module mode_seq_edge #(
  parameter int STAGES = 2
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise
);
  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              r_rise;

  // Registered rise detect keeps the edge pulse glitch-free and one cycle wide.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
      r_rise <= r_sync[STAGES-1] & ~r_prev;
    end
  end

  assign o_rise = r_rise;
endmodule

module mode_sequencer #(
  parameter int                    NUM_MODES        = 3,
  parameter int                    CMD_W            = 2,
  parameter int                    SYNC_STAGES      = 2,
  parameter int unsigned           TIMEOUT_CYC      = 50000000,
  parameter logic [NUM_MODES-1:0]  INTERACTIVE_MASK = NUM_MODES'(4)
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic [NUM_MODES-1:0] req_i,
  input  logic                 finish_i,
  input  logic                 xfer_done_i,
  output logic                 cmd_valid_o,
  output logic [CMD_W-1:0]     cmd_code_o,
  output logic                 pay_start_o,
  output logic [CMD_W-1:0]     active_mode_o,
  output logic [2:0]           state_o,
  output logic                 busy_o,
  output logic                 timeout_o,
  output logic [7:0]           err_cnt_o
);
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
  localparam bit TMO_EN = (TIMEOUT_CYC != 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_PAY  = 3'd2,
    S_HOLD = 3'd3,
    S_RET  = 3'd4
  } state_t;

  state_t               r_state, w_next;
  logic [NUM_MODES-1:0] w_req_rise;
  logic                 w_fin_rise;
  logic [NUM_MODES-1:0] r_mode_oh;
  logic [CMD_W-1:0]     r_mode;
  logic [CMD_W-1:0]     r_cmd_code;
  logic                 r_cmd_valid, r_pay_start;
  logic                 r_fresh, r_fin_latch;
  logic [CNT_W-1:0]     r_cnt;
  logic [7:0]           r_err;

  logic                 w_sel_hit;
  logic [CMD_W-1:0]     w_sel_code;
  logic [NUM_MODES-1:0] w_sel_oh;
  logic                 w_own_rise, w_interactive, w_fin_pend;
  logic                 w_wait, w_done, w_tmo;
  logic                 w_cmd_vld, w_pay_start;
  logic [CMD_W-1:0]     w_cmd_code;
  logic                 w_enter;

  genvar g;
  generate
    for (g = 0; g < NUM_MODES; g++) begin : g_req
      mode_seq_edge #(.STAGES(SYNC_STAGES)) u_req_edge (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .i_d     (req_i[g]),
        .o_rise  (w_req_rise[g])
      );
    end
  endgenerate

  mode_seq_edge #(.STAGES(SYNC_STAGES)) u_fin_edge (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .i_d     (finish_i),
    .o_rise  (w_fin_rise)
  );

  // Lowest-index edge wins; one-hot isolates the lowest set bit.
  always_comb begin
    w_sel_code = '0;
    for (int i = NUM_MODES - 1; i >= 0; i--)
      if (w_req_rise[i]) w_sel_code = CMD_W'(i + 1);
  end
  assign w_sel_hit = |w_req_rise;
  assign w_sel_oh  = w_req_rise & ~(w_req_rise - NUM_MODES'(1));

  assign w_own_rise    = |(w_req_rise & r_mode_oh);
  assign w_interactive = |(INTERACTIVE_MASK & r_mode_oh);
  assign w_fin_pend    = r_fin_latch | w_fin_rise;

  // The cycle right after a launch pulse (r_fresh) neither accepts done nor counts.
  assign w_wait = (r_state == S_CMD) || (r_state == S_PAY) || (r_state == S_RET);
  assign w_done = w_wait && !r_fresh && xfer_done_i;
  assign w_tmo  = TMO_EN && w_wait && !r_fresh && !xfer_done_i && (r_cnt == TMO_LAST);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_fresh     <= 1'b0;
      r_cnt       <= '0;
      r_cmd_valid <= 1'b0;
      r_pay_start <= 1'b0;
      r_cmd_code  <= '0;
      r_mode      <= '0;
      r_mode_oh   <= '0;
      r_fin_latch <= 1'b0;
      r_err       <= 8'd0;
    end else begin
      r_state     <= w_next;
      r_fresh     <= w_enter;
      r_cmd_valid <= w_cmd_vld;
      r_pay_start <= w_pay_start;
      if (w_cmd_vld) r_cmd_code <= w_cmd_code;
      if (w_enter)
        r_cnt <= '0;
      else if (w_wait && !r_fresh)
        r_cnt <= r_cnt + CMD_W'(0) + CNT_W'(1);
      if (r_state == S_IDLE && w_sel_hit) begin
        r_mode    <= w_sel_code;
        r_mode_oh <= w_sel_oh;
      end else if (w_next == S_IDLE && r_state != S_IDLE) begin
        r_mode    <= '0;
        r_mode_oh <= '0;
      end
      if (w_next == S_RET || w_next == S_IDLE)
        r_fin_latch <= 1'b0;
      else if ((r_state == S_CMD || r_state == S_PAY) && w_interactive && w_fin_rise)
        r_fin_latch <= 1'b1;
      if (w_tmo && r_err != 8'hFF) r_err <= r_err + 8'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_sel_hit) w_next = S_CMD;
      S_CMD: begin
        if (w_done)     w_next = S_PAY;
        else if (w_tmo) w_next = S_IDLE;
      end
      S_PAY: begin
        if (w_done)     w_next = (!w_interactive || w_fin_pend) ? S_RET : S_HOLD;
        else if (w_tmo) w_next = S_IDLE;
      end
      S_HOLD: begin
        if (w_fin_rise)      w_next = S_RET;
        else if (w_own_rise) w_next = S_PAY;
      end
      S_RET: if (w_done || w_tmo) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Every entry into a waiting state coincides with exactly one launch pulse.
  always_comb begin
    w_cmd_vld   = 1'b0;
    w_pay_start = 1'b0;
    w_cmd_code  = '0;
    case (r_state)
      S_IDLE: if (w_sel_hit) begin
        w_cmd_vld  = 1'b1;
        w_cmd_code = w_sel_code;
      end
      S_CMD: if (w_done) w_pay_start = 1'b1;
      S_PAY: if (w_done && (!w_interactive || w_fin_pend)) w_cmd_vld = 1'b1;
      S_HOLD: begin
        if (w_fin_rise)      w_cmd_vld   = 1'b1;
        else if (w_own_rise) w_pay_start = 1'b1;
      end
      default: ;
    endcase
  end
  assign w_enter = w_cmd_vld | w_pay_start;

  assign cmd_valid_o   = r_cmd_valid;
  assign cmd_code_o    = r_cmd_code;
  assign pay_start_o   = r_pay_start;
  assign active_mode_o = r_mode;
  assign state_o       = r_state;
  assign busy_o        = (r_state != S_IDLE);
  assign timeout_o     = w_tmo;
  assign err_cnt_o     = r_err;
endmodule

// File: tb/tb_mode_sequencer.sv
// Scoreboard bench for mode_sequencer: expected pulses are queued as stimulus
// is applied and checked by a monitor as the DUT emits them.

module tb_mode_sequencer;
  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req_i = 3'b000;
  logic       finish_i = 1'b0;
  logic       xfer_done_i = 1'b0;
  logic       cmd_valid_o, pay_start_o, busy_o, timeout_o;
  logic [1:0] cmd_code_o, active_mode_o;
  logic [2:0] state_o;
  logic [7:0] err_cnt_o;

  int total = 0;
  int bad = 0;

  typedef struct { int kind; logic [1:0] code; } exp_t;  // kind 0=cmd 1=pay 2=timeout
  exp_t exp_q[$];

  mode_sequencer #(
    .NUM_MODES(3), .CMD_W(2), .SYNC_STAGES(2), .TIMEOUT_CYC(16), .INTERACTIVE_MASK(3'b100)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .req_i(req_i), .finish_i(finish_i),
    .xfer_done_i(xfer_done_i), .cmd_valid_o(cmd_valid_o), .cmd_code_o(cmd_code_o),
    .pay_start_o(pay_start_o), .active_mode_o(active_mode_o), .state_o(state_o),
    .busy_o(busy_o), .timeout_o(timeout_o), .err_cnt_o(err_cnt_o)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic void push(input int kind, input logic [1:0] code);
    exp_t e;
    e.kind = kind;
    e.code = code;
    exp_q.push_back(e);
  endfunction

  always @(negedge sys_clk) begin
    exp_t e;
    if (rst_n) begin
      if (cmd_valid_o && pay_start_o) begin
        total++; bad++;
        $display("FAIL pulse_overlap cmd_valid and pay_start both high, required exclusive");
      end
      if (cmd_valid_o) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL cmd_unexpected got code %0d, required no pulse", cmd_code_o);
        end else begin
          e = exp_q.pop_front();
          if (e.kind !== 0 || e.code !== cmd_code_o) begin
            bad++; $display("FAIL cmd_pulse got cmd code %0d, required kind %0d code %0d", cmd_code_o, e.kind, e.code);
          end
        end
      end
      if (pay_start_o) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL pay_unexpected got pay_start, required no pulse");
        end else begin
          e = exp_q.pop_front();
          if (e.kind !== 1) begin
            bad++; $display("FAIL pay_pulse got pay_start, required kind %0d", e.kind);
          end
        end
      end
      if (timeout_o) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL tmo_unexpected got timeout, required no pulse");
        end else begin
          e = exp_q.pop_front();
          if (e.kind !== 2) begin
            bad++; $display("FAIL tmo_pulse got timeout, required kind %0d", e.kind);
          end
        end
      end
    end
  end

  // Returns at the negedge where the selected output is high; n = negedges waited.
  task automatic wait_sig(input int which, output int n, output bit hit);
    n = 0;
    hit = 0;
    while (n < 200) begin
      if ((which == 0 && cmd_valid_o) || (which == 1 && pay_start_o) || (which == 2 && timeout_o)) begin
        hit = 1;
        break;
      end
      @(negedge sys_clk);
      n++;
    end
  endtask

  task automatic pulse_done();
    @(negedge sys_clk) xfer_done_i = 1'b1;
    @(negedge sys_clk) xfer_done_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sys_clk);
    total++;
    if ({cmd_valid_o, cmd_code_o, pay_start_o, active_mode_o, state_o, busy_o, timeout_o, err_cnt_o} !== '0) begin
      bad++; $display("FAIL reset_outputs got state %0d busy %0b err %0d, required all zero", state_o, busy_o, err_cnt_o);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_basic();
    int n; bit hit;
    push(0, 2'd2);
    req_i = 3'b010;
    wait_sig(0, n, hit);
    total++;
    // Sampling edge k precedes the 1st negedge; pulse occupies cycle k+3.
    if (!hit || n != 4) begin
      bad++; $display("FAIL basic_latency got %0d negedges hit %0b, required 4", n, hit);
    end
    @(negedge sys_clk);
    total++;
    if (active_mode_o !== 2'd2 || state_o !== 3'd1) begin
      bad++; $display("FAIL basic_cmd_state got mode %0d state %0d, required 2 1", active_mode_o, state_o);
    end
    push(1, 2'd0);
    xfer_done_i = 1'b1;
    @(negedge sys_clk) xfer_done_i = 1'b0;
    wait_sig(1, n, hit);
    push(0, 2'd0);
    pulse_done();
    wait_sig(0, n, hit);
    total++;
    if (!hit || state_o !== 3'd4) begin
      bad++; $display("FAIL basic_ret got state %0d hit %0b, required 4", state_o, hit);
    end
    pulse_done();
    total++;
    if (busy_o !== 1'b0 || active_mode_o !== 2'd0 || state_o !== 3'd0) begin
      bad++; $display("FAIL basic_idle got busy %0b mode %0d state %0d, required 0 0 0", busy_o, active_mode_o, state_o);
    end
    repeat (10) @(negedge sys_clk);
    req_i = 3'b000;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic test_priority();
    int n; bit hit;
    push(0, 2'd2);
    req_i = 3'b110;
    wait_sig(0, n, hit);
    total++;
    if (!hit || active_mode_o !== 2'd2) begin
      bad++; $display("FAIL prio_mode got mode %0d hit %0b, required 2", active_mode_o, hit);
    end
    push(1, 2'd0);
    pulse_done();
    wait_sig(1, n, hit);
    push(0, 2'd0);
    pulse_done();
    wait_sig(0, n, hit);
    pulse_done();
    repeat (12) @(negedge sys_clk);
    total++;
    if (state_o !== 3'd0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL prio_held got state %0d busy %0b, required idle", state_o, busy_o);
    end
    req_i = 3'b000;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic test_interactive();
    int n; bit hit;
    push(0, 2'd3);
    req_i = 3'b100;
    wait_sig(0, n, hit);
    push(1, 2'd0);
    pulse_done();
    wait_sig(1, n, hit);
    pulse_done();
    @(negedge sys_clk);
    total++;
    if (state_o !== 3'd3 || active_mode_o !== 2'd3 || !busy_o) begin
      bad++; $display("FAIL inter_hold got state %0d mode %0d, required 3 3", state_o, active_mode_o);
    end
    pulse_done();
    repeat (2) @(negedge sys_clk);
    total++;
    if (state_o !== 3'd3) begin
      bad++; $display("FAIL inter_done_in_hold got state %0d, required 3", state_o);
    end
    for (int r = 0; r < 2; r++) begin
      req_i = 3'b000;
      repeat (4) @(negedge sys_clk);
      push(1, 2'd0);
      req_i = 3'b100;
      wait_sig(1, n, hit);
      total++;
      if (!hit) begin
        bad++; $display("FAIL inter_relaunch %0d got no pay_start, required pulse", r);
      end
      pulse_done();
      @(negedge sys_clk);
    end
    total++;
    if (state_o !== 3'd3) begin
      bad++; $display("FAIL inter_back_hold got state %0d, required 3", state_o);
    end
    push(0, 2'd0);
    finish_i = 1'b1;
    wait_sig(0, n, hit);
    total++;
    if (!hit || state_o !== 3'd4) begin
      bad++; $display("FAIL inter_finish got state %0d hit %0b, required 4", state_o, hit);
    end
    pulse_done();
    total++;
    if (state_o !== 3'd0 || active_mode_o !== 2'd0) begin
      bad++; $display("FAIL inter_exit got state %0d mode %0d, required 0 0", state_o, active_mode_o);
    end
    finish_i = 1'b0;
    req_i = 3'b000;
    repeat (5) @(negedge sys_clk);
  endtask

  task automatic test_finish_latch();
    int n; bit hit;
    push(0, 2'd3);
    req_i = 3'b100;
    wait_sig(0, n, hit);
    push(1, 2'd0);
    pulse_done();
    wait_sig(1, n, hit);
    finish_i = 1'b1;
    repeat (6) @(negedge sys_clk);
    push(0, 2'd0);
    pulse_done();
    wait_sig(0, n, hit);
    total++;
    if (!hit || n != 0 || state_o !== 3'd4) begin
      bad++; $display("FAIL latch_ret got state %0d wait %0d hit %0b, required 4 0 1", state_o, n, hit);
    end
    pulse_done();
    total++;
    if (state_o !== 3'd0) begin
      bad++; $display("FAIL latch_idle got state %0d, required 0", state_o);
    end
    finish_i = 1'b0;
    req_i = 3'b000;
    repeat (5) @(negedge sys_clk);
  endtask

  task automatic test_timeout();
    int n; bit hit; int miss;
    push(0, 2'd1);
    push(2, 2'd0);
    req_i = 3'b001;
    wait_sig(0, n, hit);
    wait_sig(2, n, hit);
    total++;
    if (!hit || n != 16) begin
      bad++; $display("FAIL tmo_cycle got %0d waiting cycles hit %0b, required 16", n, hit);
    end
    @(negedge sys_clk);
    total++;
    if (state_o !== 3'd0 || err_cnt_o !== 8'd1 || active_mode_o !== 2'd0) begin
      bad++; $display("FAIL tmo_after got state %0d err %0d mode %0d, required 0 1 0", state_o, err_cnt_o, active_mode_o);
    end
    miss = 0;
    for (int r = 0; r < 255; r++) begin
      req_i = 3'b000;
      repeat (4) @(negedge sys_clk);
      push(0, 2'd1);
      push(2, 2'd0);
      req_i = 3'b001;
      wait_sig(2, n, hit);
      if (!hit) miss++;
    end
    @(negedge sys_clk);
    total++;
    if (miss != 0 || err_cnt_o !== 8'd255) begin
      bad++; $display("FAIL tmo_saturate got err %0d misses %0d, required 255 0", err_cnt_o, miss);
    end
    req_i = 3'b000;
    repeat (5) @(negedge sys_clk);
  endtask

  task automatic test_reset_mid();
    int n; bit hit;
    push(0, 2'd1);
    req_i = 3'b001;
    wait_sig(0, n, hit);
    push(1, 2'd0);
    pulse_done();
    wait_sig(1, n, hit);
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b0;
    req_i = 3'b000;
    #1;
    total++;
    if ({cmd_valid_o, cmd_code_o, pay_start_o, active_mode_o, state_o, busy_o, timeout_o, err_cnt_o} !== '0) begin
      bad++; $display("FAIL rst_mid got state %0d err %0d code %0d, required all zero", state_o, err_cnt_o, cmd_code_o);
    end
    @(negedge sys_clk) rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    pulse_done();
    repeat (3) @(negedge sys_clk);
    total++;
    if (state_o !== 3'd0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL stale_done got state %0d busy %0b, required idle", state_o, busy_o);
    end
    push(0, 2'd1);
    req_i = 3'b001;
    wait_sig(0, n, hit);
    total++;
    if (!hit || n != 4) begin
      bad++; $display("FAIL relaunch got %0d negedges hit %0b, required 4", n, hit);
    end
    push(1, 2'd0);
    pulse_done();
    wait_sig(1, n, hit);
    push(0, 2'd0);
    pulse_done();
    wait_sig(0, n, hit);
    pulse_done();
    total++;
    if (state_o !== 3'd0 || active_mode_o !== 2'd0) begin
      bad++; $display("FAIL relaunch_idle got state %0d mode %0d, required 0 0", state_o, active_mode_o);
    end
    req_i = 3'b000;
    repeat (3) @(negedge sys_clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_interactive();
    test_finish_latch();
    test_timeout();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain got %0d pending, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
